ysyx_24110026_ifetch_resp: RTL and testbench
============================================

# ysyx_24110026_ifetch_resp

Instruction-fetch responder: the memory side of the core's `pc` → `inst` fetch path. It accepts one fetch address at a time over a valid/ready request channel and holds a word-addressed instruction store. It returns the 32-bit instruction over a valid/ready response channel after a fixed, parameterised latency. A side load port lets the simulation harness preload the program image before and during reset release.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: instruction words stored; power of two.
- `BASE_ADDR`, default 32'h80000000: byte address of word 0, equal to the core reset `pc`.
- `LATENCY`, default 2: cycles from request accept to `rsp_valid`; legal range 1..7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: responder can accept a request this cycle.
- `req_addr` in 32: byte fetch address (the core's `pc`).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester consumes the response this cycle.
- `rsp_inst` out 32: fetched instruction.
- `rsp_err` out 1: the fetch was misaligned or out of range.
- `ld_en` in 1: preload write strobe.
- `ld_idx` in log2(DEPTH_WORDS): word index for the preload.
- `ld_data` in 32: preload word.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Accept condition: `req_valid & req_ready`.
- `req_ready` = `~rst & (state==IDLE | (state==RESP & rsp_ready))`.
- On accept:
  - Compute `off = req_addr - BASE_ADDR`.
  - `err = req_addr[1:0]!=0 | off[31:2] >= DEPTH_WORDS`.
  - Capture into the pending registers: `data = err ? 32'h0 : mem[off[2+:log2(DEPTH_WORDS)]]`, and `err`.
  - The read happens at the accept edge. A later `ld_en` write does not alter an in-flight response.
- Transitions:
  - IDLE→WAIT on accept with LATENCY>1; the counter loads LATENCY-2.
  - IDLE→RESP on accept with LATENCY==1.
  - WAIT: the counter decrements each cycle; WAIT→RESP when the counter is 0.
  - RESP→IDLE on `rsp_ready` with no new accept.
  - RESP→WAIT or RESP on `rsp_ready` with a simultaneous accept; the pending registers are overwritten by the new request.
  - RESP holds state and data while `rsp_ready` is 0.
- `rsp_valid` = (state==RESP). `rsp_inst` and `rsp_err` are driven from the pending registers in RESP and are 0 otherwise.
- Preload: when `ld_en`, `mem[ld_idx] <= ld_data` at the clock edge. Preloads are legal in every state and also during `rst`; memory is not reset.
- Same-cycle preload and accept to the same word: the accept reads the old word (read-before-write).
- Reset mid-operation: any in-flight or pending response is dropped. The state returns to IDLE and the requester must re-issue.

## Timing
- Reset values: state=IDLE, counter=0, pending data/err=0. `req_ready`=0 while `rst` is high and 1 in the first cycle after release. `rsp_valid`=0, `rsp_inst`=0, `rsp_err`=0.
- Accept at edge N → `rsp_valid` is high in the cycle following edge N+LATENCY-1, i.e. exactly LATENCY cycles after the request cycle.
- Sustained throughput with `rsp_ready` held at 1: one instruction every LATENCY cycles, because RESP overlaps the next accept.
- No combinational path from `req_*` to `rsp_*`. `req_ready` depends combinationally on `rsp_ready` only in RESP.
- Counter is 3 bits wide. Address arithmetic is 32-bit modulo 2^32, so addresses below `BASE_ADDR` wrap to large offsets and flag `err`.

## Structure
- Package `ysyx_24110026_pkg` holds:
  - the FSM state typedef (IDLE/WAIT/RESP);
  - the constant `IFETCH_ERR_INST=32'h0`;
  - the default `BASE_ADDR`.
- Sub-module `ysyx_24110026_ifetch_mem`: the DEPTH_WORDS×32 array with one synchronous write port (preload) and one read port. The top block owns the FSM, counter, range check and pending registers.

## Test plan
- Preload `idx0=32'h00500093`, LATENCY=2; request 32'h80000000 with `rsp_ready`=1 → `rsp_valid` 2 cycles later with `rsp_inst`=32'h00500093, `rsp_err`=0.
- Request 32'h80000002 → `rsp_err`=1, `rsp_inst`=0. Request 32'h7FFFFFFC → `rsp_err`=1. Request 32'h80001000 with DEPTH_WORDS=1024 → `rsp_err`=1.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_inst` and `rsp_err` stay stable and `req_ready`=0. Then pulse `rsp_ready` with `req_valid`=1 at 32'h80000004 → same-cycle accept, next response 2 cycles later.
- LATENCY=1, `req_valid` held, `rsp_ready`=1, addresses 0x80000000/4/8 → one response per cycle in order.
- Accept a request, then assert `rst` during WAIT → `rsp_valid` never rises. After release `req_ready`=1 and a new fetch completes normally.
- `ld_en` writes 32'hDEADBEEF to idx 1 in the same cycle as a fetch of 0x80000004 → the response carries the old word; a re-fetch returns 32'hDEADBEEF.

Source files
------------

// File: rtl/ysyx_24110026_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ysyx_24110026_pkg;

    // Responder FSM: idle, counting down the fetch latency, presenting a response.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } ifetch_state_e;

    // Instruction word returned alongside rsp_err for a faulting fetch.
    localparam logic [31:0] IFETCH_ERR_INST  = 32'h0000_0000;

    // Byte address of instruction word 0 (matches the core reset pc).
    localparam logic [31:0] IFETCH_BASE_ADDR = 32'h8000_0000;

    // Latency down-counter width; covers LATENCY up to 7.
    localparam int IFETCH_CNT_W = 3;

endpackage

// File: rtl/ysyx_24110026_ifetch_mem.sv
// Instruction store: DEPTH_WORDS x 32 array, one synchronous write port for
// program preload and one asynchronous read port sampled by the responder.
// Because the read is combinational and the write lands at the clock edge, a
// same-edge write and capture to one word returns the old contents.
module ysyx_24110026_ifetch_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Preload write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/ysyx_24110026_ifetch_resp.sv
// Instruction-fetch responder: accepts one fetch address at a time, reads the
// instruction store at the accept edge, and returns the word (or an error)
// exactly LATENCY cycles later over a valid/ready response channel.
module ysyx_24110026_ifetch_resp
    import ysyx_24110026_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = IFETCH_BASE_ADDR,
    parameter int          LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_inst,
    output logic                           rsp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [31:0]                    ld_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // WAIT is entered with LATENCY-2 and left when the counter reads zero,
    // which puts RESP exactly LATENCY cycles after the request cycle.
    localparam logic [IFETCH_CNT_W-1:0] CNT_LOAD =
        (LATENCY > 1) ? IFETCH_CNT_W'(LATENCY - 2) : '0;
    localparam logic [IFETCH_CNT_W-1:0] CNT_ONE  = IFETCH_CNT_W'(1);

    // State after an accept: straight to RESP only for single-cycle latency.
    localparam ifetch_state_e ACCEPT_STATE = (LATENCY > 1) ? S_WAIT : S_RESP;

    ifetch_state_e           state_q, state_d;
    logic [IFETCH_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]             data_q, data_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic [29:0]             off_word;
    logic [1:0]              off_byte_unused;
    logic                    addr_err;
    logic [31:0]             mem_rd_data;

    // Modulo-2^32 offset: addresses below BASE_ADDR wrap to huge word offsets
    // and so fall out of range. Alignment is judged on the raw address.
    assign {off_word, off_byte_unused} = req_addr - BASE_ADDR;
    assign addr_err = (req_addr[1:0] != 2'b00)
                    | ({2'b00, off_word} >= 32'(DEPTH_WORDS));

    // Ready in IDLE, or in RESP when the current response drains this cycle;
    // never while reset is held.
    assign req_ready = ~rst & ((state_q == S_IDLE)
                             | ((state_q == S_RESP) & rsp_ready));
    assign accept    = req_valid & req_ready;

    ysyx_24110026_ifetch_mem #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .rd_idx  (off_word[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    // State, counter and pending response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = ACCEPT_STATE;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        state_d = ACCEPT_STATE;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending response capture: the store is read at the accept edge, so a
    // later preload cannot disturb a response already in flight.
    always_comb begin
        data_d = data_q;
        err_d  = err_q;
        if (accept) begin
            data_d = addr_err ? IFETCH_ERR_INST : mem_rd_data;
            err_d  = addr_err;
        end
    end

    // Response outputs come only from registers and are zero outside RESP.
    always_comb begin
        rsp_valid = (state_q == S_RESP);
        rsp_inst  = rsp_valid ? data_q : '0;
        rsp_err   = rsp_valid & err_q;
    end

endmodule

// File: tb/tb_ysyx_24110026_ifetch_resp.sv
// Bench for the instruction-fetch responder: one instance at LATENCY=2 and one
// at LATENCY=1 share clock, reset and preload port. A negedge monitor predicts
// each accepted fetch into a per-instance queue and checks responses on pop.
`timescale 1ns/1ps
module tb_ysyx_24110026_ifetch_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;

    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] req_addr = '0, rsp_inst;

    logic        req_valid_1 = 1'b0, req_ready_1, rsp_valid_1, rsp_ready_1 = 1'b0, rsp_err_1;
    logic [31:0] req_addr_1 = '0, rsp_inst_1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q2[$];
    exp_t        q1[$];
    bit          seen2 = 0, seen1 = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] w [8];

    ysyx_24110026_ifetch_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    ysyx_24110026_ifetch_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut_1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_inst(rsp_inst_1), .rsp_err(rsp_err_1),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t predict(input logic [31:0] addr, input int due);
        exp_t        e;
        logic [31:0] off;
        off   = addr - BASE;
        e.err = (addr[1:0] != 2'b00) || (off[31:2] >= 30'(DEPTH));
        e.inst = e.err ? 32'h0 : model[off[11:2]];
        e.due  = due;
        return e;
    endfunction

    // Scoreboard: check responses, then record new accepts, then apply preloads
    // to the model (an accept this cycle sees the old word).
    always @(negedge clk) begin
        if (rst) begin
            q2.delete();
            q1.delete();
            seen2 = 0;
            seen1 = 0;
        end else begin
            if (rsp_valid) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL l2_unexpected_rsp got inst=%h err=%b, no response expected", rsp_inst, rsp_err);
                end else begin
                    if (!seen2) begin
                        checks++;
                        if (cyc !== q2[0].due) begin
                            errors++;
                            $display("FAIL l2_latency rsp_valid at cycle %0d, expected cycle %0d", cyc, q2[0].due);
                        end
                        seen2 = 1;
                    end
                    if (rsp_ready) begin
                        checks++;
                        if (rsp_inst !== q2[0].inst || rsp_err !== q2[0].err) begin
                            errors++;
                            $display("FAIL l2_rsp got inst=%h err=%b expected inst=%h err=%b",
                                     rsp_inst, rsp_err, q2[0].inst, q2[0].err);
                        end
                        q2.delete(0);
                        seen2 = 0;
                    end
                end
            end
            if (rsp_valid_1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL l1_unexpected_rsp got inst=%h err=%b, no response expected", rsp_inst_1, rsp_err_1);
                end else begin
                    if (!seen1) begin
                        checks++;
                        if (cyc !== q1[0].due) begin
                            errors++;
                            $display("FAIL l1_latency rsp_valid at cycle %0d, expected cycle %0d", cyc, q1[0].due);
                        end
                        seen1 = 1;
                    end
                    if (rsp_ready_1) begin
                        checks++;
                        if (rsp_inst_1 !== q1[0].inst || rsp_err_1 !== q1[0].err) begin
                            errors++;
                            $display("FAIL l1_rsp got inst=%h err=%b expected inst=%h err=%b",
                                     rsp_inst_1, rsp_err_1, q1[0].inst, q1[0].err);
                        end
                        q1.delete(0);
                        seen1 = 0;
                    end
                end
            end
            if (req_valid && req_ready)     q2.push_back(predict(req_addr, cyc + 2));
            if (req_valid_1 && req_ready_1) q1.push_back(predict(req_addr_1, cyc + 1));
        end
        if (ld_en) model[ld_idx] = ld_data;
    end

    // Present a request on the LATENCY=2 instance until it is accepted.
    task automatic fetch2(input logic [31:0] addr);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL fetch_accept_timeout addr=%h req_ready=%b expected 1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) until both scoreboards are empty.
    task automatic drain();
        int n = 0;
        while ((q2.size() != 0 || q1.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q2.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending l2=%0d l1=%0d expected 0", q2.size(), q1.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            ld_en = 1'b1; ld_idx = 10'(i); ld_data = w[i];
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || req_ready_1 !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready got %b/%b expected 0/0", req_ready, req_ready_1);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_valid_1 !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got %b/%b expected 0/0", rsp_valid, rsp_valid_1);
        end
        checks++;
        if (rsp_inst !== 32'h0 || rsp_err !== 1'b0 || rsp_inst_1 !== 32'h0 || rsp_err_1 !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_data got %h/%b expected 0/0", rsp_inst, rsp_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || req_ready_1 !== 1'b1) begin
            errors++; $display("FAIL release_req_ready got %b/%b expected 1/1", req_ready, req_ready_1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        rsp_ready = 1'b1;
        fetch2(BASE);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_wait_valid got %b expected 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0050_0093 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL basic_rsp got v=%b inst=%h err=%b expected v=1 inst=00500093 err=0",
                               rsp_valid, rsp_inst, rsp_err);
        end
        drain();
    endtask

    task automatic test_err();
        logic [31:0] bad [3];
        bad[0] = 32'h8000_0002;
        bad[1] = 32'h7FFF_FFFC;
        bad[2] = 32'h8000_1000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch2(bad[i]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_inst !== 32'h0) begin
                errors++; $display("FAIL err_rsp addr=%h got v=%b err=%b inst=%h expected v=1 err=1 inst=0",
                                   bad[i], rsp_valid, rsp_err, rsp_inst);
            end
            drain();
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        fetch2(BASE + 32'd8);
        req_valid = 1'b1;
        req_addr  = BASE + 32'd4;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0020_8193 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold cyc%0d got v=%b inst=%h err=%b rdy=%b expected v=1 inst=00208193 err=0 rdy=0",
                                   i, rsp_valid, rsp_inst, rsp_err, req_ready);
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_same_cycle_accept req_ready got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_next_wait rsp_valid got %b expected 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0010_0113) begin
            errors++; $display("FAIL stall_next_rsp got v=%b inst=%h expected v=1 inst=00100113", rsp_valid, rsp_inst);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        rsp_ready_1 = 1'b1;
        req_valid_1 = 1'b1;
        req_addr_1  = BASE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) req_addr_1 = BASE + 32'(4 * (i + 1));
            else       req_valid_1 = 1'b0;
            @(negedge clk);
            checks++;
            if (rsp_valid_1 !== 1'b1 || rsp_inst_1 !== w[i] || rsp_err_1 !== 1'b0) begin
                errors++; $display("FAIL l1_stream beat%0d got v=%b inst=%h err=%b expected v=1 inst=%h err=0",
                                   i, rsp_valid_1, rsp_inst_1, rsp_err_1, w[i]);
            end
        end
        drain();
    endtask

    task automatic test_ld_collision();
        rsp_ready = 1'b1;
        ld_en     = 1'b1;
        ld_idx    = 10'd1;
        ld_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = BASE + 32'd4;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL collide_ready got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        ld_en     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0010_0113) begin
            errors++; $display("FAIL collide_old_word got v=%b inst=%h expected v=1 inst=00100113", rsp_valid, rsp_inst);
        end
        drain();
        fetch2(BASE + 32'd4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL collide_new_word got v=%b inst=%h expected v=1 inst=deadbeef", rsp_valid, rsp_inst);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        fetch2(BASE + 32'd12);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_hold got v=%b rdy=%b expected v=0 rdy=0", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL midrst_after cyc%0d got v=%b rdy=%b expected v=0 rdy=1", i, rsp_valid, req_ready);
            end
        end
        @(posedge clk); #1;
        fetch2(BASE + 32'd12);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0031_0233 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_refetch got v=%b inst=%h err=%b expected v=1 inst=00310233 err=0",
                               rsp_valid, rsp_inst, rsp_err);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        w[0] = 32'h0050_0093;
        w[1] = 32'h0010_0113;
        w[2] = 32'h0020_8193;
        w[3] = 32'h0031_0233;
        w[4] = 32'h0042_02B3;
        w[5] = 32'h0052_8333;
        w[6] = 32'h0063_03B3;
        w[7] = 32'h0073_8433;
        test_reset();
        test_basic();
        test_err();
        test_stall();
        test_back_to_back();
        test_ld_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
